dbg_mem_bridge: RTL and testbench
=================================

// Module: dbg_mem_bridge
// PURPOSE
//  Downstream stage of the UART debug command processor. Turns its addr / data_out / data_out_ready /
//  data_imem_p_dmem_n outputs into req/ack accesses on the debug memory master port.
//  Returns data_in, data_in_valid and data_write_complete to the command processor.
//  Keeps a 1-word read cache of the current address so a read command sees valid data at once.
//  Touches memory only while the CPU is halted.
// PARAMETERS
//  TIMEOUT_CYCLES  256         max cycles waiting for mem_ack; 0 = no timeout
//  READ_ERR_VALUE  32'hDEADBEEF  data returned by a read that times out
// PORTS
//  clk                  in   1   clock
//  rst_n                in   1   reset, asynchronous, active-low
//  addr                 in   32  debug address (byte address; bits [1:0] ignored)
//  data_imem_p_dmem_n   in   1   1 = instruction memory, 0 = data memory
//  data_out             in   32  write data
//  data_out_ready       in   1   write request (level, held while the command processor waits)
//  cpu_halt             in   1   1 = CPU halted, bridge may own memory
//  data_in              out  32  cached read data
//  data_in_valid        out  1   data_in matches current addr/space (combinational from regs)
//  data_write_complete  out  1   write done; held until data_out_ready low
//  mem_req              out  1   access request, held until mem_ack or timeout
//  mem_we               out  1   1 = write access
//  mem_imem_p_dmem_n    out  1   target space of access
//  mem_addr             out  32  {addr[31:2],2'b00}, captured at access start
//  mem_wdata            out  32  write data, captured at access start
//  mem_rdata            in   32  read data, valid with mem_ack on a read
//  mem_ack              in   1   1-cycle completion, sampled only while mem_req=1
//  timeout_err          out  1   sticky: some access timed out
// BEHAVIOUR
//  Reset: all outputs 0 (data_in=0, data_in_valid=0, mem_req=0); cache invalid; state IDLE.
//  Reset mid-access drops mem_req immediately. No memory access is left pending.
//  Cache
//   - Registers: cvalid, ctag = addr[31:2], cspace.
//   - data_in_valid = cvalid & cpu_halt & state==IDLE & ctag==addr[31:2] & cspace==data_imem_p_dmem_n.
//   - cvalid is cleared:
//     - every cycle cpu_halt=0, because the running CPU may change memory;
//     - at the start of any write.
//  FSM states: IDLE, READ, WRITE, WDONE.
//   IDLE, in priority order:
//    - cpu_halt=0 -> stay.
//    - data_out_ready & armed -> WRITE.
//    - ~data_in_valid -> READ (refill).
//    - else stay.
//   On entry to READ/WRITE, on the same edge:
//    - capture mem_addr, mem_wdata, mem_we, mem_imem_p_dmem_n;
//    - assert mem_req;
//    - clear the timeout counter.
//   READ + mem_ack -> IDLE; data_in <= mem_rdata; cvalid <= 1; ctag/cspace <= captured values.
//    mem_req drops on the same edge.
//   WRITE + mem_ack -> WDONE; mem_req drops.
//   WDONE: data_write_complete=1 and armed <= 0. When data_out_ready=0 -> IDLE; complete drops.
//  Write re-arm
//   - armed is set whenever data_out_ready=0.
//   - A held data_out_ready therefore causes exactly one write.
//  Refill after a write
//   - The cache is invalid after a write, so IDLE refills the current address automatically.
//  Addr/space change while IDLE and halted: data_in_valid falls in the same cycle; a refill starts on the next edge.
//  Addr/space change during READ: the access completes with the old address. The tag mismatches, so a second refill follows.
//  cpu_halt falls mid-access: the access runs to ack/timeout; the bridge then idles; the cache stays invalid.
//  Timeout (TIMEOUT_CYCLES>0)
//   - Counter increments each cycle in READ/WRITE.
//   - At count TIMEOUT_CYCLES-1 without ack: mem_req drops; timeout_err <= 1.
//   - READ: data_in <= READ_ERR_VALUE, cvalid <= 1.
//   - WRITE: goes to WDONE, so the command processor never hangs.
//  mem_ack while mem_req=0 is ignored. Latency: read result visible on data_in_valid the cycle after mem_ack.
// TESTING
//  1 Halted; addr=0x100, dmem; mem returns 0x12345678 with ack 3 cycles after req
//    -> one read with mem_addr=0x100, mem_we=0; data_in=0x12345678, data_in_valid=1 the cycle after ack.
//  2 Write: data_out=0xCAFEF00D, data_out_ready held 5 cycles past complete
//    -> exactly one mem_we=1 access to 0x100.
//    -> data_write_complete high until ready low; then an automatic refill read of 0x100.
//  3 cpu_halt=0 with addr changing
//    -> mem_req stays 0, data_in_valid=0.
//    -> halt=1 -> refill of the new addr within 1 cycle.
//  4 Read with mem_ack never asserted, TIMEOUT_CYCLES=8
//    -> mem_req drops after 8 cycles; data_in=0xDEADBEEF valid; timeout_err=1 until reset.
//  5 addr 0x200 -> 0x204 during an in-flight read
//    -> first read completes; a second read to 0x204 follows; valid only with the 0x204 data.
//  6 rst_n low mid-WRITE
//    -> mem_req=0 asynchronously; all outputs 0; after release, a refill starts when halted.

Source files
------------

// File: rtl/dbg_mem_bridge.sv
// dbg_mem_bridge: turns debug command processor accesses into req/ack
// memory accesses, with a 1-word read cache of the current address.
module dbg_mem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] READ_ERR_VALUE = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        data_imem_p_dmem_n,
    input  logic [31:0] data_out,
    input  logic        data_out_ready,
    input  logic        cpu_halt,
    output logic [31:0] data_in,
    output logic        data_in_valid,
    output logic        data_write_complete,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_imem_p_dmem_n,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_WDONE
    } state_t;

    localparam int unsigned CW =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    state_t        r_state;
    logic          r_cvalid;
    logic [29:0]   r_ctag;
    logic          r_cspace;
    logic [31:0]   r_data_in;
    logic          r_armed;
    logic          r_req;
    logic          r_we;
    logic          r_space;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [CW-1:0] r_cnt;
    logic          r_terr;
    logic          r_wc;

    logic          w_hit;
    logic          w_timeout;
    logic          w_unused;

    // Cache hit only when the bridge is idle and the CPU cannot touch memory
    always_comb begin
        w_hit = r_cvalid & cpu_halt & (r_state == S_IDLE)
              & (r_ctag == addr[31:2])
              & (r_cspace == data_imem_p_dmem_n);
        w_timeout = TO_EN && (r_cnt == CNT_LAST);
    end

    assign w_unused = ^addr[1:0];

    // Access FSM, cache and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cvalid  <= 1'b0;
            r_ctag    <= '0;
            r_cspace  <= 1'b0;
            r_data_in <= '0;
            r_armed   <= 1'b0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_space   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_terr    <= 1'b0;
            r_wc      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (!cpu_halt) begin
                        r_state <= S_IDLE;
                    end else if (data_out_ready && r_armed) begin
                        r_state  <= S_WRITE;
                        r_req    <= 1'b1;
                        r_we     <= 1'b1;
                        r_space  <= data_imem_p_dmem_n;
                        r_addr   <= {addr[31:2], 2'b00};
                        r_wdata  <= data_out;
                        r_cnt    <= '0;
                        r_cvalid <= 1'b0;
                    end else if (!w_hit) begin
                        r_state <= S_READ;
                        r_req   <= 1'b1;
                        r_we    <= 1'b0;
                        r_space <= data_imem_p_dmem_n;
                        r_addr  <= {addr[31:2], 2'b00};
                        r_wdata <= data_out;
                        r_cnt   <= '0;
                    end
                end
                S_READ: begin
                    if (mem_ack || w_timeout) begin
                        r_state   <= S_IDLE;
                        r_req     <= 1'b0;
                        r_data_in <= mem_ack ? mem_rdata : READ_ERR_VALUE;
                        r_cvalid  <= 1'b1;
                        r_ctag    <= r_addr[31:2];
                        r_cspace  <= r_space;
                        if (!mem_ack) begin
                            r_terr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (mem_ack || w_timeout) begin
                        r_state <= S_WDONE;
                        r_req   <= 1'b0;
                        r_wc    <= 1'b1;
                        if (!mem_ack) begin
                            r_terr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WDONE: begin
                    r_armed <= 1'b0;
                    if (!data_out_ready) begin
                        r_state <= S_IDLE;
                        r_wc    <= 1'b0;
                    end
                end
            endcase
            // A released request re-arms the next write, overriding WDONE
            if (!data_out_ready) begin
                r_armed <= 1'b1;
            end
            // A running CPU may change memory, so the cache can never hold
            if (!cpu_halt) begin
                r_cvalid <= 1'b0;
            end
        end
    end

    assign data_in             = r_data_in;
    assign data_in_valid       = w_hit;
    assign data_write_complete = r_wc;
    assign mem_req             = r_req;
    assign mem_we              = r_we;
    assign mem_imem_p_dmem_n   = r_space;
    assign mem_addr            = r_addr;
    assign mem_wdata           = r_wdata;
    assign timeout_err         = r_terr;

endmodule

// File: tb/tb_dbg_mem_bridge.sv
// tb_dbg_mem_bridge: directed checks of the debug memory bridge
// against a small req/ack memory responder.
module tb_dbg_mem_bridge;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic        space;
    logic [31:0] data_out;
    logic        data_out_ready;
    logic        cpu_halt;
    logic [31:0] data_in;
    logic        data_in_valid;
    logic        data_write_complete;
    logic        mem_req;
    logic        mem_we;
    logic        mem_imem_p_dmem_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        timeout_err;

    int n_chk;
    int n_err;
    int n_acc;
    int lat;
    bit ack_en;
    int rcnt;

    logic [31:0] mem [logic [32:0]];

    dbg_mem_bridge #(
        .TIMEOUT_CYCLES(8),
        .READ_ERR_VALUE(32'hDEADBEEF)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .addr               (addr),
        .data_imem_p_dmem_n (space),
        .data_out           (data_out),
        .data_out_ready     (data_out_ready),
        .cpu_halt           (cpu_halt),
        .data_in            (data_in),
        .data_in_valid      (data_in_valid),
        .data_write_complete(data_write_complete),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_imem_p_dmem_n  (mem_imem_p_dmem_n),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata),
        .mem_ack            (mem_ack),
        .timeout_err        (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: acks lat negedges after a request is first seen
    always @(negedge clk) begin
        logic [32:0] key;
        if (!mem_req) begin
            rcnt    = 0;
            mem_ack = 1'b0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else begin
            if (rcnt == 0) n_acc++;
            rcnt++;
            if (ack_en && rcnt >= lat) begin
                mem_ack = 1'b1;
                key = {mem_imem_p_dmem_n, mem_addr};
                if (mem_we) mem[key] = mem_wdata;
                else mem_rdata = mem.exists(key) ? mem[key] : 32'h0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // which: 0 = data_in_valid high, 1 = write complete high, 2 = mem_req low
    task automatic wait_until(input int which, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            case (which)
                0: ok = data_in_valid;
                1: ok = data_write_complete;
                default: ok = !mem_req;
            endcase
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        int hi;
        n_chk = 0; n_err = 0; n_acc = 0; rcnt = 0;
        lat = 3; ack_en = 1'b1;
        mem_ack = 1'b0; mem_rdata = '0;
        rst_n = 1'b0; cpu_halt = 1'b0; addr = 32'h100; space = 1'b0;
        data_out = '0; data_out_ready = 1'b0;
        mem[{1'b0, 32'h100}] = 32'h12345678;
        mem[{1'b0, 32'h200}] = 32'hAAAA0200;
        mem[{1'b0, 32'h204}] = 32'hBBBB0204;

        repeat (2) @(negedge clk);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_din", data_in, 0);
        chk("rst_valid", 32'(data_in_valid), 0);
        chk("rst_wc", 32'(data_write_complete), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("run_noreq", 32'(mem_req), 0);

        // 1: refill read of 0x100
        cpu_halt = 1'b1;
        @(negedge clk);
        chk("t1_req", 32'(mem_req), 1);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_we", 32'(mem_we), 0);
        repeat (2) @(negedge clk);
        chk("t1_notyet", 32'(data_in_valid), 0);
        @(negedge clk);
        chk("t1_valid", 32'(data_in_valid), 1);
        chk("t1_data", data_in, 32'h12345678);
        chk("t1_reqlo", 32'(mem_req), 0);
        @(negedge clk);
        chk("t1_nacc", n_acc, 1);

        // 2: held write, one access, then refill
        data_out = 32'hCAFEF00D;
        data_out_ready = 1'b1;
        @(negedge clk);
        chk("t2_req", 32'(mem_req), 1);
        chk("t2_we", 32'(mem_we), 1);
        chk("t2_addr", mem_addr, 32'h100);
        chk("t2_wdata", mem_wdata, 32'hCAFEF00D);
        chk("t2_inval", 32'(data_in_valid), 0);
        wait_until(1, "t2_wc_wait");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_wc_hold", 32'(data_write_complete), 1);
        end
        chk("t2_noreq", 32'(mem_req), 0);
        chk("t2_nacc", n_acc, 2);
        data_out_ready = 1'b0;
        @(negedge clk);
        chk("t2_wc_lo", 32'(data_write_complete), 0);
        @(negedge clk);
        chk("t2_refill", 32'(mem_req), 1);
        chk("t2_refwe", 32'(mem_we), 0);
        wait_until(0, "t2_valid_wait");
        chk("t2_data", data_in, 32'hCAFEF00D);
        chk("t2_nacc3", n_acc, 3);

        // 3: running CPU with addr changes
        cpu_halt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_req", 32'(mem_req), 0);
            chk("t3_valid", 32'(data_in_valid), 0);
            addr = 32'h180 + 32'(i * 4);
        end
        addr = 32'h200;
        cpu_halt = 1'b1;
        @(negedge clk);
        chk("t3_req_on", 32'(mem_req), 1);
        chk("t3_addr", mem_addr, 32'h200);
        wait_until(0, "t3_valid_wait");
        chk("t3_data", data_in, 32'hAAAA0200);
        chk("t3_terr", 32'(timeout_err), 0);

        // 4: read timeout
        ack_en = 1'b0;
        addr = 32'h300;
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req) hi++;
            else if (hi > 0) break;
        end
        chk("t4_reqcyc", hi, 8);
        chk("t4_data", data_in, 32'hDEADBEEF);
        chk("t4_valid", 32'(data_in_valid), 1);
        chk("t4_terr", 32'(timeout_err), 1);
        ack_en = 1'b1;

        // 5: address change during an in-flight read
        lat = 4;
        addr = 32'h200;
        @(negedge clk);
        chk("t5_addr0", mem_addr, 32'h200);
        addr = 32'h204;
        wait_until(2, "t5_done_wait");
        chk("t5_stale", 32'(data_in_valid), 0);
        chk("t5_olddata", data_in, 32'hAAAA0200);
        @(negedge clk);
        chk("t5_req2", 32'(mem_req), 1);
        chk("t5_addr2", mem_addr, 32'h204);
        wait_until(0, "t5_valid_wait");
        chk("t5_data", data_in, 32'hBBBB0204);
        chk("t5_terr", 32'(timeout_err), 1);

        // 6: reset in the middle of a write
        lat = 6;
        data_out = 32'h11112222;
        data_out_ready = 1'b1;
        @(negedge clk);
        chk("t6_req", 32'(mem_req), 1);
        chk("t6_we", 32'(mem_we), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_req_async", 32'(mem_req), 0);
        chk("t6_we0", 32'(mem_we), 0);
        chk("t6_addr0", mem_addr, 0);
        chk("t6_din0", data_in, 0);
        chk("t6_terr0", 32'(timeout_err), 0);
        chk("t6_wc0", 32'(data_write_complete), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_refill", 32'(mem_req), 1);
        chk("t6_refwe", 32'(mem_we), 0);
        chk("t6_refaddr", mem_addr, 32'h204);
        wait_until(0, "t6_valid_wait");
        chk("t6_data", data_in, 32'hBBBB0204);
        data_out_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
